pmp_access_arbiter: RTL and testbench
=====================================

// Module: pmp_access_arbiter
// PURPOSE
//  Shares one pmp instance between three requesters: instruction fetch (execute checks), LSU (read/write checks)
//  and the CSR unit (pmpcfg/pmpaddr reads and writes). Grants one requester per cycle and drives the pmp
//  check/CSR ports from the winner. Registers the pmp result into a per-requester response one cycle later.
//  Blocks checks for one cycle after any CSR write so the new configuration is applied before the next check.
// PARAMETERS
//  XLEN        32  address/data width of all check and CSR paths
//  STARVE_MAX  4   consecutive denied fetch cycles after which fetch outranks the LSU
//  CNT_W       3   width of starvation counter; must hold STARVE_MAX
// PORTS
//  clock          in   1     system clock, all state on rising edge
//  reset          in   1     asynchronous, active-low reset (0 = reset)
//  if_req         in   1     fetch check request, held until if_gnt
//  if_addr        in   XLEN  fetch address
//  if_priv        in   2     privilege mode of fetch
//  if_gnt         out  1     fetch request accepted this cycle
//  if_rsp_valid   out  1     fetch result valid (1 cycle pulse)
//  if_fault       out  1     fetch denied; meaningful only with if_rsp_valid
//  lsu_req        in   1     LSU check request, held until lsu_gnt
//  lsu_we         in   1     1 = WRITE check, 0 = READ check
//  lsu_addr       in   XLEN  data address
//  lsu_size       in   2     access size, passed to pmp size
//  lsu_priv       in   2     privilege mode of access
//  lsu_gnt        out  1     LSU request accepted this cycle
//  lsu_rsp_valid  out  1     LSU result valid (1 cycle pulse)
//  lsu_fault      out  1     LSU access denied
//  csr_req        in   1     CSR access request, held until csr_gnt
//  csr_we         in   1     1 = write, 0 = read
//  csr_addr       in   XLEN  CSR number (CSR_PMPCFG0, CSR_PMPADDR0..)
//  csr_wdata      in   XLEN  CSR write data
//  csr_gnt        out  1     CSR request accepted this cycle
//  csr_rsp_valid  out  1     CSR access complete (1 cycle pulse)
//  csr_rdata      out  XLEN  CSR read data, valid with csr_rsp_valid on reads, 0 after writes
//  pmp_wr_en, pmp_rw_addr, pmp_wdata, pmp_addr, pmp_priv_mode, pmp_size, pmp_oper  out  -> pmp inputs
//  pmp_rdata      in   XLEN  pmp CSR read data (combinational)
//  pmp_permission in   2     pmp check result (combinational); 2'b01 = allowed, any other value = fault
// BEHAVIOUR
//  States: IDLE (grants allowed), SETTLE (no grants). Reset -> IDLE.
//  Reset (reset=0, async): all gnt/rsp_valid/fault = 0, csr_rdata = 0, starvation counter = 0, state IDLE.
//   Pending responses are dropped. pmp_wr_en = 0.
//  Arbitration in IDLE, combinational, one grant max per cycle: csr > lsu > fetch.
//   If starve_cnt == STARVE_MAX: csr > fetch > lsu.
//  gnt asserts in the same cycle as req when that requester wins. Requester drops or changes req after gnt.
//  pmp drive follows the winner. For fetch: oper = EXECUTE, size = 2'b10. For LSU: oper = WRITE if lsu_we else READ.
//   For CSR: pmp_rw_addr = csr_addr, pmp_wdata = csr_wdata, pmp_wr_en = csr_we.
//  No grant: pmp_wr_en = 0, pmp_oper = READ, pmp_addr = 0.
//  Latency 1: on the next edge, the winner's rsp_valid = 1 for exactly one cycle.
//   fault = (pmp_permission != 2'b01).
//   csr_rdata = pmp_rdata, captured on reads.
//  Back-to-back grants are allowed every cycle in IDLE.
//  A granted CSR write moves IDLE -> SETTLE. SETTLE lasts 1 cycle, grants nothing, then returns to IDLE.
//   CSR reads do not enter SETTLE.
//  starve_cnt: +1 each cycle if_req=1 and if_gnt=0; saturates at STARVE_MAX.
//   Cleared to 0 on if_gnt or when if_req=0.
//  Simultaneous req from all three: csr wins; the other two stay pending, no gnt.
//  In SETTLE all gnt = 0 regardless of req. The starvation counter still counts.
// TESTING
//  1. Reset then idle: all gnt/rsp 0.
//     Assert reset mid-response (rsp_valid=1) -> rsp_valid 0 immediately, state IDLE.
//  2. CSR write CSR_PMPADDR0=32'h20000000 -> csr_gnt same cycle, pmp_wr_en=1 one cycle.
//     csr_rsp_valid next cycle; lsu_req held during SETTLE gets no gnt until 2 cycles after csr_gnt.
//  3. cfg0 X=1,R=W=0 NAPOT; fetch 32'h20000000 priv=01 -> if_fault=0.
//     LSU read same addr -> lsu_fault=1; each response 1 cycle after its gnt.
//  4. Fetch and LSU requesting continuously (STARVE_MAX=4) -> LSU granted 4 cycles, fetch 5th.
//     Counter then clears and the pattern repeats.
//  5. csr, lsu and if req all high in one cycle -> only csr_gnt. Next cycle: lsu_gnt for a read, or none if CSR wrote (SETTLE).
//  6. CSR read of CSR_PMPCFG0 after writing 32'h0F8D1F0C -> csr_rdata = 32'h0F8D1F0C with csr_rsp_valid.

Source files
------------

// File: rtl/pmp_access_arbiter.sv
// pmp_access_arbiter
// Shares a single pmp instance between instruction fetch, the LSU and the
// CSR unit. One requester is granted per cycle (csr > lsu > fetch, with fetch
// promoted above the LSU once it has been starved long enough). The pmp
// result is registered into the winner's response one cycle after its grant.
// A CSR write is followed by one SETTLE cycle with no grants so the new
// configuration is in effect before any further check.
module pmp_access_arbiter #(
   parameter int XLEN       = 32,
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic            clock,
   input  logic            reset,

   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   input  logic [1:0]      if_priv,
   output logic            if_gnt,
   output logic            if_rsp_valid,
   output logic            if_fault,

   input  logic            lsu_req,
   input  logic            lsu_we,
   input  logic [XLEN-1:0] lsu_addr,
   input  logic [1:0]      lsu_size,
   input  logic [1:0]      lsu_priv,
   output logic            lsu_gnt,
   output logic            lsu_rsp_valid,
   output logic            lsu_fault,

   input  logic            csr_req,
   input  logic            csr_we,
   input  logic [XLEN-1:0] csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic            csr_gnt,
   output logic            csr_rsp_valid,
   output logic [XLEN-1:0] csr_rdata,

   output logic            pmp_wr_en,
   output logic [XLEN-1:0] pmp_rw_addr,
   output logic [XLEN-1:0] pmp_wdata,
   output logic [XLEN-1:0] pmp_addr,
   output logic [1:0]      pmp_priv_mode,
   output logic [1:0]      pmp_size,
   output logic [1:0]      pmp_oper,
   input  logic [XLEN-1:0] pmp_rdata,
   input  logic [1:0]      pmp_permission
);

   // Encoding of the pmp operation port
   localparam logic [1:0] OPER_READ    = 2'b00;
   localparam logic [1:0] OPER_WRITE   = 2'b01;
   localparam logic [1:0] OPER_EXECUTE = 2'b10;

   // Fetch is always a word-sized check
   localparam logic [1:0] FETCH_SIZE   = 2'b10;

   // pmp reports 2'b01 when the access is allowed
   localparam logic [1:0] PERM_ALLOWED = 2'b01;

   localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

   typedef enum logic {
      IDLE,
      SETTLE
   } state_t;

   state_t            r_state;
   state_t            w_nextState;

   logic [CNT_W-1:0]  r_starveCnt;
   logic              w_fetchFirst;

   logic              w_ifGnt;
   logic              w_lsuGnt;
   logic              w_csrGnt;
   logic              w_allowed;

   logic              r_ifRspValid;
   logic              r_ifFault;
   logic              r_lsuRspValid;
   logic              r_lsuFault;
   logic              r_csrRspValid;
   logic [XLEN-1:0]   r_csrRdata;

   assign w_fetchFirst = (r_starveCnt == STARVE_LIMIT);
   assign w_allowed    = (pmp_permission == PERM_ALLOWED);

   // Pick at most one winner per cycle; nobody wins while the new config settles
   always_comb begin
      w_ifGnt  = 1'b0;
      w_lsuGnt = 1'b0;
      w_csrGnt = 1'b0;
      if (r_state == IDLE) begin
         if (csr_req) begin
            w_csrGnt = 1'b1;
         end else if (w_fetchFirst) begin
            if (if_req) begin
               w_ifGnt = 1'b1;
            end else if (lsu_req) begin
               w_lsuGnt = 1'b1;
            end
         end else begin
            if (lsu_req) begin
               w_lsuGnt = 1'b1;
            end else if (if_req) begin
               w_ifGnt = 1'b1;
            end
         end
      end
   end

   // A granted CSR write forces one quiet cycle before the next check
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_csrGnt && csr_we) begin
               w_nextState = SETTLE;
            end
         end
         SETTLE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Steer the shared pmp ports from whichever requester won this cycle
   always_comb begin
      pmp_wr_en     = 1'b0;
      pmp_rw_addr   = '0;
      pmp_wdata     = '0;
      pmp_addr      = '0;
      pmp_priv_mode = 2'b00;
      pmp_size      = 2'b00;
      pmp_oper      = OPER_READ;
      if (w_ifGnt) begin
         pmp_addr      = if_addr;
         pmp_priv_mode = if_priv;
         pmp_size      = FETCH_SIZE;
         pmp_oper      = OPER_EXECUTE;
      end else if (w_lsuGnt) begin
         pmp_addr      = lsu_addr;
         pmp_priv_mode = lsu_priv;
         pmp_size      = lsu_size;
         pmp_oper      = lsu_we ? OPER_WRITE : OPER_READ;
      end else if (w_csrGnt) begin
         pmp_rw_addr   = csr_addr;
         pmp_wdata     = csr_wdata;
         pmp_wr_en     = csr_we;
      end
   end

   // Arbitration state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Count how long fetch has waited; it only builds while fetch is asking
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_starveCnt <= '0;
      end else if (!if_req || w_ifGnt) begin
         r_starveCnt <= '0;
      end else if (r_starveCnt != STARVE_LIMIT) begin
         r_starveCnt <= r_starveCnt + 1'b1;
      end
   end

   // Capture the pmp result for the winner and present it for one cycle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ifRspValid  <= 1'b0;
         r_ifFault     <= 1'b0;
         r_lsuRspValid <= 1'b0;
         r_lsuFault    <= 1'b0;
         r_csrRspValid <= 1'b0;
      end else begin
         r_ifRspValid  <= w_ifGnt;
         r_ifFault     <= w_ifGnt & ~w_allowed;
         r_lsuRspValid <= w_lsuGnt;
         r_lsuFault    <= w_lsuGnt & ~w_allowed;
         r_csrRspValid <= w_csrGnt;
      end
   end

   // CSR read data is latched on reads and zeroed after writes
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_csrRdata <= '0;
      end else if (w_csrGnt) begin
         r_csrRdata <= csr_we ? '0 : pmp_rdata;
      end
   end

   assign if_gnt        = w_ifGnt;
   assign lsu_gnt       = w_lsuGnt;
   assign csr_gnt       = w_csrGnt;
   assign if_rsp_valid  = r_ifRspValid;
   assign if_fault      = r_ifFault;
   assign lsu_rsp_valid = r_lsuRspValid;
   assign lsu_fault     = r_lsuFault;
   assign csr_rsp_valid = r_csrRspValid;
   assign csr_rdata     = r_csrRdata;

endmodule

// File: tb/tb_pmp_access_arbiter.sv
// Testbench for pmp_access_arbiter. A small behavioural pmp stands in for the
// real one: it stores pmpcfg0/pmpaddr0 and allows an access when the region
// is enabled, the 4 KiB page of the address matches pmpaddr0 and the R/W/X
// bit for the operation is set. Expected responses are queued when a grant
// is expected and compared when the response cycle arrives.
module tb_pmp_access_arbiter;

   localparam int XLEN = 32;

   localparam logic [31:0] CSR_PMPCFG0  = 32'h3A0;
   localparam logic [31:0] CSR_PMPADDR0 = 32'h3B0;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_EXEC  = 2'b10;

   typedef struct {
      logic [1:0]  who;
      logic        fault;
      logic [31:0] rdata;
   } rsp_t;

   logic            clock;
   logic            reset;
   logic            if_req;
   logic [XLEN-1:0] if_addr;
   logic [1:0]      if_priv;
   logic            if_gnt;
   logic            if_rsp_valid;
   logic            if_fault;
   logic            lsu_req;
   logic            lsu_we;
   logic [XLEN-1:0] lsu_addr;
   logic [1:0]      lsu_size;
   logic [1:0]      lsu_priv;
   logic            lsu_gnt;
   logic            lsu_rsp_valid;
   logic            lsu_fault;
   logic            csr_req;
   logic            csr_we;
   logic [XLEN-1:0] csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic            csr_gnt;
   logic            csr_rsp_valid;
   logic [XLEN-1:0] csr_rdata;
   logic            pmp_wr_en;
   logic [XLEN-1:0] pmp_rw_addr;
   logic [XLEN-1:0] pmp_wdata;
   logic [XLEN-1:0] pmp_addr;
   logic [1:0]      pmp_priv_mode;
   logic [1:0]      pmp_size;
   logic [1:0]      pmp_oper;
   logic [XLEN-1:0] pmp_rdata;
   logic [1:0]      pmp_permission;

   logic [31:0]     stubCfg0;
   logic [31:0]     stubAddr0;

   rsp_t            sb[$];
   logic [2:0]      lastGnt;
   int              checks;
   int              errors;

   pmp_access_arbiter #(
      .XLEN(32),
      .STARVE_MAX(4),
      .CNT_W(3)
   ) dut (
      .clock(clock),
      .reset(reset),
      .if_req(if_req),
      .if_addr(if_addr),
      .if_priv(if_priv),
      .if_gnt(if_gnt),
      .if_rsp_valid(if_rsp_valid),
      .if_fault(if_fault),
      .lsu_req(lsu_req),
      .lsu_we(lsu_we),
      .lsu_addr(lsu_addr),
      .lsu_size(lsu_size),
      .lsu_priv(lsu_priv),
      .lsu_gnt(lsu_gnt),
      .lsu_rsp_valid(lsu_rsp_valid),
      .lsu_fault(lsu_fault),
      .csr_req(csr_req),
      .csr_we(csr_we),
      .csr_addr(csr_addr),
      .csr_wdata(csr_wdata),
      .csr_gnt(csr_gnt),
      .csr_rsp_valid(csr_rsp_valid),
      .csr_rdata(csr_rdata),
      .pmp_wr_en(pmp_wr_en),
      .pmp_rw_addr(pmp_rw_addr),
      .pmp_wdata(pmp_wdata),
      .pmp_addr(pmp_addr),
      .pmp_priv_mode(pmp_priv_mode),
      .pmp_size(pmp_size),
      .pmp_oper(pmp_oper),
      .pmp_rdata(pmp_rdata),
      .pmp_permission(pmp_permission)
   );

   // Free-running clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Behavioural pmp permission rule shared by the stub and the expectations
   function automatic logic [1:0] stubPerm(input logic [1:0] oper, input logic [31:0] addr,
                                           input logic [31:0] cfg, input logic [31:0] a0);
      logic [7:0] b;
      logic       ok;
      b  = cfg[7:0];
      ok = 1'b0;
      if (b[4:3] != 2'b00 && addr[31:12] == a0[31:12]) begin
         case (oper)
            OP_READ:  ok = b[0];
            OP_WRITE: ok = b[1];
            OP_EXEC:  ok = b[2];
            default:  ok = 1'b0;
         endcase
      end
      return ok ? 2'b01 : 2'b10;
   endfunction

   assign pmp_permission = stubPerm(pmp_oper, pmp_addr, stubCfg0, stubAddr0);
   assign pmp_rdata = (pmp_rw_addr == CSR_PMPCFG0)  ? stubCfg0 :
                      (pmp_rw_addr == CSR_PMPADDR0) ? stubAddr0 : 32'h0;

   // Stub pmp CSR storage updated by the arbiter's write strobe
   initial begin
      stubCfg0  = 32'h0;
      stubAddr0 = 32'h0;
   end
   always @(posedge clock) begin
      if (pmp_wr_en) begin
         if (pmp_rw_addr == CSR_PMPCFG0)  stubCfg0  <= pmp_wdata;
         if (pmp_rw_addr == CSR_PMPADDR0) stubAddr0 <= pmp_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check grants for the inputs already driven and queue the expected response
   task automatic applyStimulus(input string tag, input logic eIf, input logic eLsu,
                                input logic eCsr, input logic [31:0] eRdata);
      rsp_t r;
      #1;
      chk({tag, "_ifGnt"},  {31'b0, if_gnt},  {31'b0, eIf});
      chk({tag, "_lsuGnt"}, {31'b0, lsu_gnt}, {31'b0, eLsu});
      chk({tag, "_csrGnt"}, {31'b0, csr_gnt}, {31'b0, eCsr});
      if (eIf) begin
         r.who   = 2'd0;
         r.fault = (stubPerm(OP_EXEC, if_addr, stubCfg0, stubAddr0) != 2'b01);
         r.rdata = 32'h0;
         sb.push_back(r);
      end
      if (eLsu) begin
         r.who   = 2'd1;
         r.fault = (stubPerm(lsu_we ? OP_WRITE : OP_READ, lsu_addr, stubCfg0, stubAddr0) != 2'b01);
         r.rdata = 32'h0;
         sb.push_back(r);
      end
      if (eCsr) begin
         r.who   = 2'd2;
         r.fault = 1'b0;
         r.rdata = eRdata;
         sb.push_back(r);
      end
      lastGnt = {eCsr, eLsu, eIf};
   endtask

   // Advance one clock, drop granted requests and compare the response cycle
   task automatic checkOutput(input string tag);
      rsp_t r;
      @(posedge clock);
      #1;
      if (lastGnt[0]) if_req  = 1'b0;
      if (lastGnt[1]) lsu_req = 1'b0;
      if (lastGnt[2]) csr_req = 1'b0;
      lastGnt = 3'b000;
      if (sb.size() > 0) begin
         r = sb.pop_front();
         chk({tag, "_ifRspValid"},  {31'b0, if_rsp_valid},  {31'b0, r.who == 2'd0});
         chk({tag, "_lsuRspValid"}, {31'b0, lsu_rsp_valid}, {31'b0, r.who == 2'd1});
         chk({tag, "_csrRspValid"}, {31'b0, csr_rsp_valid}, {31'b0, r.who == 2'd2});
         if (r.who == 2'd0) chk({tag, "_ifFault"},  {31'b0, if_fault},  {31'b0, r.fault});
         if (r.who == 2'd1) chk({tag, "_lsuFault"}, {31'b0, lsu_fault}, {31'b0, r.fault});
         if (r.who == 2'd2) chk({tag, "_csrRdata"}, csr_rdata, r.rdata);
      end else begin
         chk({tag, "_noRsp"}, {29'b0, if_rsp_valid, lsu_rsp_valid, csr_rsp_valid}, 32'h0);
      end
   endtask

   task automatic csrSet(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      csr_req   = 1'b1;
      csr_we    = we;
      csr_addr  = addr;
      csr_wdata = wdata;
   endtask

   // Directed sequence
   initial begin
      checks  = 0;
      errors  = 0;
      lastGnt = 3'b000;
      reset   = 1'b0;
      if_req  = 1'b0; if_addr  = 32'h0; if_priv  = 2'b00;
      lsu_req = 1'b0; lsu_we   = 1'b0;  lsu_addr = 32'h0; lsu_size = 2'b10; lsu_priv = 2'b01;
      csr_req = 1'b0; csr_we   = 1'b0;  csr_addr = 32'h0; csr_wdata = 32'h0;

      // Reset state
      #12;
      chk("rst_gnts", {29'b0, if_gnt, lsu_gnt, csr_gnt}, 32'h0);
      chk("rst_rsps", {29'b0, if_rsp_valid, lsu_rsp_valid, csr_rsp_valid}, 32'h0);
      chk("rst_faults", {30'b0, if_fault, lsu_fault}, 32'h0);
      chk("rst_rdata", csr_rdata, 32'h0);
      chk("rst_wren", {31'b0, pmp_wr_en}, 32'h0);
      reset = 1'b1;

      $display("[TB] idle after reset");
      applyStimulus("idle0", 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("idle0");

      $display("[TB] CSR write pmpaddr0 with LSU waiting through SETTLE");
      csrSet(1'b1, CSR_PMPADDR0, 32'h2000_0000);
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h2000_0000;
      applyStimulus("wrAddr", 1'b0, 1'b0, 1'b1, 32'h0);
      chk("wrAddr_wrEn", {31'b0, pmp_wr_en}, 32'h1);
      chk("wrAddr_rwAddr", pmp_rw_addr, CSR_PMPADDR0);
      chk("wrAddr_wdata", pmp_wdata, 32'h2000_0000);
      checkOutput("wrAddr");
      applyStimulus("settle1", 1'b0, 1'b0, 1'b0, 32'h0);
      chk("settle1_wrEn", {31'b0, pmp_wr_en}, 32'h0);
      checkOutput("settle1");
      applyStimulus("lsuAfterSettle", 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("lsuAfterSettle");

      $display("[TB] X-only NAPOT region: fetch allowed, LSU read denied");
      csrSet(1'b1, CSR_PMPCFG0, 32'h0000_001C);
      applyStimulus("wrCfg", 1'b0, 1'b0, 1'b1, 32'h0);
      checkOutput("wrCfg");
      applyStimulus("settle2", 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("settle2");
      if_req = 1'b1; if_addr = 32'h2000_0000; if_priv = 2'b01;
      applyStimulus("fetchX", 1'b1, 1'b0, 1'b0, 32'h0);
      chk("fetchX_oper", {30'b0, pmp_oper}, {30'b0, OP_EXEC});
      chk("fetchX_size", {30'b0, pmp_size}, 32'h2);
      chk("fetchX_addr", pmp_addr, 32'h2000_0000);
      chk("fetchX_priv", {30'b0, pmp_priv_mode}, 32'h1);
      checkOutput("fetchX");
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h2000_0000;
      applyStimulus("lsuRd", 1'b0, 1'b1, 1'b0, 32'h0);
      chk("lsuRd_oper", {30'b0, pmp_oper}, {30'b0, OP_READ});
      checkOutput("lsuRd");
      applyStimulus("idle1", 1'b0, 1'b0, 1'b0, 32'h0);
      chk("idle1_addr", pmp_addr, 32'h0);
      chk("idle1_oper", {30'b0, pmp_oper}, {30'b0, OP_READ});
      checkOutput("idle1");

      $display("[TB] fetch starvation against continuous LSU writes");
      lsu_we = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if_req  = 1'b1;
         lsu_req = 1'b1;
         applyStimulus($sformatf("starve%0d", k), (k % 5) == 4, (k % 5) != 4, 1'b0, 32'h0);
         checkOutput($sformatf("starve%0d", k));
      end
      if_req = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0;
      applyStimulus("idle2", 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("idle2");

      $display("[TB] all three requesting, CSR read then CSR write");
      csrSet(1'b0, CSR_PMPCFG0, 32'h0);
      if_req = 1'b1; lsu_req = 1'b1;
      applyStimulus("all3Rd", 1'b0, 1'b0, 1'b1, 32'h0000_001C);
      checkOutput("all3Rd");
      applyStimulus("all3RdLsu", 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("all3RdLsu");
      applyStimulus("all3RdIf", 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("all3RdIf");
      csrSet(1'b1, CSR_PMPCFG0, 32'h0F8D_1F0C);
      if_req = 1'b1; lsu_req = 1'b1;
      applyStimulus("all3Wr", 1'b0, 1'b0, 1'b1, 32'h0);
      checkOutput("all3Wr");
      applyStimulus("all3WrSettle", 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("all3WrSettle");
      applyStimulus("all3WrLsu", 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("all3WrLsu");
      applyStimulus("all3WrIf", 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("all3WrIf");

      $display("[TB] read back pmpcfg0");
      csrSet(1'b0, CSR_PMPCFG0, 32'h0);
      applyStimulus("rdCfg", 1'b0, 1'b0, 1'b1, 32'h0F8D_1F0C);
      checkOutput("rdCfg");

      $display("[TB] reset during a response");
      csrSet(1'b0, CSR_PMPADDR0, 32'h0);
      applyStimulus("rstMid", 1'b0, 1'b0, 1'b1, 32'h2000_0000);
      @(posedge clock);
      #1;
      csr_req = 1'b0;
      lastGnt = 3'b000;
      sb.delete();
      chk("rstMid_rspBefore", {31'b0, csr_rsp_valid}, 32'h1);
      chk("rstMid_rdataBefore", csr_rdata, 32'h2000_0000);
      reset = 1'b0;
      #1;
      chk("rstMid_rspAfter", {31'b0, csr_rsp_valid}, 32'h0);
      chk("rstMid_rdataAfter", csr_rdata, 32'h0);
      #3;
      reset = 1'b1;
      applyStimulus("postRst", 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("postRst");
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h0000_1000;
      applyStimulus("postRstLsu", 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("postRstLsu");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
